fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000; PC value loaded on reset.
REQ-002 clock  input  1  single clock, all state updates on posedge clock.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 imem_addr  output  32  byte address presented to instruction memory, equal to current pc.
REQ-005 imem_data  input  32  instruction word returned combinationally for imem_addr in the same cycle.
REQ-006 id_ready  input  1  decode stage accepts the IF/ID contents this cycle.
REQ-007 redirect  input  1  branch/jump taken; flush and load redirect_pc.
REQ-008 redirect_pc  input  32  new fetch address when redirect=1.
REQ-009 id_valid  output  1  IF/ID register holds a valid instruction.
REQ-010 id_instr  output  32  registered instruction word.
REQ-011 id_pc  output  32  address id_instr was fetched from.
REQ-012 id_pc_plus4  output  32  id_pc + 4, modulo 2^32.
REQ-013 fetch_count, stall_count  output  32 each  performance counters (present only per REQ-030).

Function
REQ-014 The block SHALL hold a pc register and drive imem_addr = pc combinationally.
REQ-015 FSM states SHALL be RUN (IF/ID empty or draining), STALL (id_valid=1, id_ready=0) and FLUSH (one cycle after redirect).
REQ-016 Advance: when redirect=0 and (id_valid=0 or id_ready=1), on the clock edge IF/ID SHALL capture {imem_data, pc, pc+4}, id_valid<=1, pc<=pc+4, state<=RUN.
REQ-017 Stall: when redirect=0, id_valid=1, id_ready=0, pc and IF/ID SHALL hold unchanged, state<=STALL; id_instr SHALL be stable for the entire stall.
REQ-018 Redirect: when redirect=1, pc<={redirect_pc[31:2],2'b00}, id_valid<=0, state<=FLUSH, regardless of id_ready or state (redirect has priority).
REQ-019 FLUSH SHALL last exactly one cycle; the next cycle behaves as RUN with id_valid=0, so the redirect target appears on id_valid two edges after redirect asserts.
REQ-020 Redirect asserted in consecutive cycles SHALL take the latest redirect_pc each cycle and keep id_valid=0.
REQ-021 Fetch latency: instruction at pc SHALL appear on id_instr one edge after pc is presented; throughput one instruction per cycle with id_ready=1.
REQ-022 pc arithmetic SHALL be 32-bit unsigned modulo 2^32; 32'hFFFF_FFFC advances to 32'h0000_0000 with no flag.
REQ-023 id_instr/id_pc/id_pc_plus4 SHALL not change while id_valid=0 except by a capture (REQ-016).
REQ-024 Inputs id_ready and imem_data SHALL be ignored during a redirect cycle.

Reset
REQ-025 On reset=1, asynchronously: pc=RESET_PC, id_valid=0, id_instr=0, id_pc=0, id_pc_plus4=0, state=RUN, counters=0.
REQ-026 Reset mid-stall or mid-flush SHALL discard all state; first capture occurs on the first posedge with reset=0, fetching RESET_PC.
REQ-027 No output SHALL be X after reset assertion.

Configuration
REQ-028 Macro FETCH_PERF_COUNT_EN controls the performance counters.
REQ-029 Defined: fetch_count increments by 1 on each capture (REQ-016); stall_count increments by 1 each cycle in STALL condition; both wrap modulo 2^32; redirect cycles increment neither.
REQ-030 Undefined: fetch_count and stall_count ports and counter logic SHALL be absent; all other behaviour identical.

Verification
REQ-031 Reset release, id_ready=1, imem returns addr|32'hA000_0000 -> id_pc sequence 0,4,8,12 on consecutive edges, id_valid=1 from first edge.
REQ-032 Stall: id_ready=0 for 3 cycles while id_pc=8 -> pc stays 12, id_instr constant, stall_count +3; release -> id_pc=12 next edge.
REQ-033 Redirect to 32'h0000_0103 while stalled -> next edge id_valid=0, pc=32'h100; following edge id_pc=32'h100, id_valid=1.
REQ-034 Wrap: RESET_PC=32'hFFFF_FFF8 -> id_pc FFFF_FFF8, FFFF_FFFC, 0000_0000; id_pc_plus4 of FFFF_FFFC = 0.
REQ-035 Async reset asserted mid-cycle during STALL -> id_valid=0 and pc=RESET_PC immediately, before next clock edge.
REQ-036 Redirect and id_ready=1 same cycle, 2 back-to-back redirects to 0x40 then 0x80 -> no capture, first valid id_pc=0x80.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch stage with a single IF/ID pipeline register.
//   Keeps the program counter, presents it to instruction memory
//   combinationally, and captures {instruction, pc, pc+4} into IF/ID when
//   decode can take it. A redirect (branch/jump) flushes IF/ID and reloads
//   pc with the word-aligned target; it has priority over everything else.
//   State machine: RUN (IF/ID empty or draining), STALL (held, decode busy),
//   FLUSH (one cycle after a redirect).
// Optional feature: define FETCH_PERF_COUNT_EN to add the fetch_count and
//   stall_count performance counters (ports and logic absent otherwise).
// Ports:
//   clock        in   clock, all state updates on posedge
//   reset        in   asynchronous active-high reset
//   imem_addr    out  [31:0] byte address to instruction memory (= pc)
//   imem_data    in   [31:0] instruction word for imem_addr, same cycle
//   id_ready     in   decode accepts IF/ID contents this cycle
//   redirect     in   branch/jump taken: flush and load redirect_pc
//   redirect_pc  in   [31:0] new fetch address (low two bits dropped)
//   id_valid     out  IF/ID holds a valid instruction
//   id_instr     out  [31:0] registered instruction word
//   id_pc        out  [31:0] address id_instr was fetched from
//   id_pc_plus4  out  [31:0] id_pc + 4, modulo 2^32
//   fetch_count  out  [31:0] captures so far      (FETCH_PERF_COUNT_EN only)
//   stall_count  out  [31:0] stalled cycles so far (FETCH_PERF_COUNT_EN only)
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        id_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4
`ifdef FETCH_PERF_COUNT_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
`endif
);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_STALL,
    ST_FLUSH
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic        r_valid;
  logic [31:0] r_instr;
  logic [31:0] r_id_pc;
  logic [31:0] r_id_pc_plus4;

  logic        w_advance;
  logic        w_stall;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_redirect_aligned;

  assign w_pc_plus4         = r_pc + 32'd4;
  assign w_redirect_aligned = redirect_pc & 32'hFFFF_FFFC;

  // IF/ID is always empty in FLUSH, so FLUSH advances exactly like an empty RUN.
  assign w_advance = ~redirect & ((r_state == ST_FLUSH) | ~r_valid | id_ready);
  assign w_stall   = ~redirect & r_valid & ~id_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= ST_RUN;
      r_pc          <= RESET_PC;
      r_valid       <= 1'b0;
      r_instr       <= '0;
      r_id_pc       <= '0;
      r_id_pc_plus4 <= '0;
    end else if (redirect) begin
      r_state <= ST_FLUSH;
      r_pc    <= w_redirect_aligned;
      r_valid <= 1'b0;
    end else if (w_advance) begin
      r_state       <= ST_RUN;
      r_pc          <= w_pc_plus4;
      r_valid       <= 1'b1;
      r_instr       <= imem_data;
      r_id_pc       <= r_pc;
      r_id_pc_plus4 <= w_pc_plus4;
    end else begin
      r_state <= ST_STALL;
    end
  end

  assign imem_addr   = r_pc;
  assign id_valid    = r_valid;
  assign id_instr    = r_instr;
  assign id_pc       = r_id_pc;
  assign id_pc_plus4 = r_id_pc_plus4;

`ifdef FETCH_PERF_COUNT_EN
  logic [31:0] r_fetch_count;
  logic [31:0] r_stall_count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_fetch_count <= '0;
      r_stall_count <= '0;
    end else begin
      if (w_advance) r_fetch_count <= r_fetch_count + 32'd1;
      if (w_stall)   r_stall_count <= r_stall_count + 32'd1;
    end
  end

  assign fetch_count = r_fetch_count;
  assign stall_count = r_stall_count;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed scenarios followed by random traffic,
// checked against a behavioural model of the fetch pipeline.
module tb_fetch_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        id_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] key;

  logic [31:0] imem_addr, imem_data, id_instr, id_pc, id_pc_plus4;
  logic        id_valid;
  logic [31:0] w_imem_addr, w_imem_data, w_instr, w_id_pc, w_id_pc_plus4;
  logic        w_valid;
`ifdef FETCH_PERF_COUNT_EN
  logic [31:0] fetch_count, stall_count, w_fetch_count, w_stall_count;
`endif

  always #5 clock = ~clock;

  // Instruction memory: word is a keyed function of its address.
  assign imem_data   = imem_addr ^ key;
  assign w_imem_data = w_imem_addr ^ key;

  fetch_stage dut (
    .clock(clock), .reset(reset), .imem_addr(imem_addr), .imem_data(imem_data),
    .id_ready(id_ready), .redirect(redirect), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc), .id_pc_plus4(id_pc_plus4)
`ifdef FETCH_PERF_COUNT_EN
    , .fetch_count(fetch_count), .stall_count(stall_count)
`endif
  );

  // Second instance starting just below the top of the address space.
  fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clock(clock), .reset(reset), .imem_addr(w_imem_addr), .imem_data(w_imem_data),
    .id_ready(id_ready), .redirect(redirect), .redirect_pc(redirect_pc),
    .id_valid(w_valid), .id_instr(w_instr), .id_pc(w_id_pc), .id_pc_plus4(w_id_pc_plus4)
`ifdef FETCH_PERF_COUNT_EN
    , .fetch_count(w_fetch_count), .stall_count(w_stall_count)
`endif
  );

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  // Behavioural model of dut (RESET_PC = 0)
  logic [31:0] m_pc, m_instr, m_id_pc, m_fetches, m_stalls;
  logic        m_valid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_valid = 1'b0; m_instr = '0; m_id_pc = '0;
    m_fetches = '0; m_stalls = '0;
  endtask

  task automatic check_outputs(input string ctx);
    chk({ctx, ".id_valid"}, {31'd0, id_valid}, {31'd0, m_valid});
    chk({ctx, ".id_instr"}, id_instr, m_instr);
    chk({ctx, ".id_pc"}, id_pc, m_id_pc);
    chk({ctx, ".id_pc_plus4"}, id_pc_plus4, m_id_pc + 32'd4 - ((m_valid || m_id_pc != 0 || m_instr != 0) ? 32'd0 : 32'd4));
    chk({ctx, ".imem_addr"}, imem_addr, m_pc);
`ifdef FETCH_PERF_COUNT_EN
    chk({ctx, ".fetch_count"}, fetch_count, m_fetches);
    chk({ctx, ".stall_count"}, stall_count, m_stalls);
`endif
  endtask

  // Drive one cycle of inputs (called just after a posedge), advance the
  // model by the fetch rules, then compare just after the next posedge.
  task automatic step(input string ctx, input logic rdy, input logic rd, input logic [31:0] tgt);
    id_ready = rdy; redirect = rd; redirect_pc = tgt;
    if (rd) begin
      m_pc    = {tgt[31:2], 2'b00};
      m_valid = 1'b0;
    end else if (!m_valid || rdy) begin
      m_instr   = m_pc ^ key;
      m_id_pc   = m_pc;
      m_valid   = 1'b1;
      m_pc      = m_pc + 32'd4;
      m_fetches = m_fetches + 32'd1;
    end else begin
      m_stalls = m_stalls + 32'd1;
    end
    @(posedge clock); #1;
    check_outputs(ctx);
  endtask

  initial begin
    logic [31:0] instr_hold;
    logic [31:0] tgt;
    reset = 1'b1; id_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    key = 32'hA000_0000;
    model_reset();

    // Reset state
    #3;
    check_outputs("reset");
    chk("reset.wrap_imem_addr", w_imem_addr, 32'hFFFF_FFF8);
    chk("reset.wrap_valid", {31'd0, w_valid}, 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;

    // Streaming: id_pc 0,4,8 with id_valid from the first edge; wrap instance too
    step("stream0", 1'b1, 1'b0, '0);
    chk("stream0.instr_or", id_instr, 32'hA000_0000);
    chk("wrap0.id_pc", w_id_pc, 32'hFFFF_FFF8);
    step("stream1", 1'b1, 1'b0, '0);
    chk("stream1.instr_or", id_instr, 32'hA000_0004);
    chk("wrap1.id_pc", w_id_pc, 32'hFFFF_FFFC);
    chk("wrap1.id_pc_plus4", w_id_pc_plus4, 32'h0000_0000);
    step("stream2", 1'b1, 1'b0, '0);
    chk("wrap2.id_pc", w_id_pc, 32'h0000_0000);
    chk("wrap2.valid", {31'd0, w_valid}, 32'd1);

    // Stall three cycles at id_pc=8
    instr_hold = id_instr;
    for (int i = 0; i < 3; i++) begin
      step("stall", 1'b0, 1'b0, '0);
      chk("stall.pc_held", imem_addr, 32'd12);
      chk("stall.instr_stable", id_instr, instr_hold);
    end
`ifdef FETCH_PERF_COUNT_EN
    chk("stall.count3", stall_count, 32'd3);
`endif
    step("release", 1'b1, 1'b0, '0);
    chk("release.id_pc", id_pc, 32'd12);

    // Redirect while stalled
    step("stall2", 1'b0, 1'b0, '0);
    step("redir", 1'b0, 1'b1, 32'h0000_0103);
    chk("redir.pc", imem_addr, 32'h100);
    chk("redir.valid", {31'd0, id_valid}, 32'd0);
    step("redir_next", 1'b1, 1'b0, '0);
    chk("redir_next.id_pc", id_pc, 32'h100);

    // Back-to-back redirects with id_ready=1
    step("b2b0", 1'b1, 1'b1, 32'h40);
    step("b2b1", 1'b1, 1'b1, 32'h80);
    chk("b2b1.valid", {31'd0, id_valid}, 32'd0);
    step("b2b2", 1'b1, 1'b0, '0);
    chk("b2b2.id_pc", id_pc, 32'h80);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      if (i % 50 == 0) key = $urandom;
      tgt = $urandom;
      if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 | tgt[3:0];
      step("rand", ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) == 0), tgt);
    end

    // Asynchronous reset in the middle of a stall
    step("pre_rst", 1'b1, 1'b0, '0);
    step("stall_rst", 1'b0, 1'b0, '0);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_outputs("async_rst");
    @(posedge clock); #1;
    reset = 1'b0;
    step("after_rst", 1'b1, 1'b0, '0);
    chk("after_rst.id_pc", id_pc, 32'h0);

    // Asynchronous reset in the middle of a flush
    step("flush_pre", 1'b1, 1'b1, 32'h0000_2000);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_outputs("flush_rst");
    @(posedge clock); #1;
    reset = 1'b0;
    step("after_flush_rst", 1'b1, 1'b0, '0);
    step("after_flush_rst2", 1'b1, 1'b0, '0);
    chk("after_flush_rst2.id_pc", id_pc, 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Global time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
